// File: rtl/swc_driver_if.sv
// ---------------------------------------------------------------------------
// swc_driver_if
// Bundles the command handshake, the stopwatch instruction bus and the
// status outputs of swc_driver into a single interface.
//
// Signals:
//   cmd_valid   command request from the host
//   cmd_ready   driver accepts a command this cycle
//   cmd_value   24-bit start value for the stopwatch counter
//   cmd_dir     0 = count down to zero, 1 = count up to wrap
//   abort       request early stop of a running count
//   swc_inst    instruction to the stopwatch ([11:8] opcode, [7:0] immediate)
//   swc_inst_en swc_inst valid this cycle
//   swc_ready   stopwatch counter next value == 0
//   busy        command in progress
//   done        one-cycle completion pulse
//   aborted     qualifies done: completion was caused by abort
//
// Modports:
//   master  host / stopwatch side (drives commands and swc_ready)
//   slave   driver side (swc_driver)
// ---------------------------------------------------------------------------
interface swc_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_value;
    logic        cmd_dir;
    logic        abort;
    logic [11:0] swc_inst;
    logic        swc_inst_en;
    logic        swc_ready;
    logic        busy;
    logic        done;
    logic        aborted;

    modport master (
        output cmd_valid, cmd_value, cmd_dir, abort, swc_ready,
        input  cmd_ready, swc_inst, swc_inst_en, busy, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_value, cmd_dir, abort, swc_ready,
        output cmd_ready, swc_inst, swc_inst_en, busy, done, aborted
    );
endinterface

// File: rtl/swc_driver.sv
// ---------------------------------------------------------------------------
// swc_driver
// Sequences a stopwatch counter: accepts a 24-bit start value and direction,
// loads it into the stopwatch as three byte-wide load instructions, starts
// the count, waits for the stopwatch to report completion (or an abort
// request), and signals completion with a one-cycle done pulse.
//
// Parameters:
//   DirUpEnable  1: cmd_dir selects up/down; 0: every command counts down
//
// Ports:
//   clock   single clock, all state changes on its rising edge
//   reset   asynchronous, active-low reset
//   bus     swc_driver_if.slave: command handshake, stopwatch instruction
//           bus and status (see swc_driver_if.sv)
//
// Every output is a flop. Outputs are decoded from the next state and
// registered, so each output reflects the state the driver is in during
// that cycle while no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module swc_driver #(
    parameter bit DirUpEnable = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    swc_driver_if.slave bus
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD0 = 4'h1;
    localparam logic [3:0] OP_LD1 = 4'h2;
    localparam logic [3:0] OP_LD2 = 4'h3;
    localparam logic [3:0] OP_CCU = 4'h6;
    localparam logic [3:0] OP_CCD = 4'h7;
    localparam logic [3:0] OP_CCS = 4'h8;

    typedef enum logic [3:0] {
        S_INIT = 4'd0,
        S_IDLE = 4'd1,
        S_LD0  = 4'd2,
        S_LD1  = 4'd3,
        S_LD2  = 4'd4,
        S_RUN  = 4'd5,
        S_WAIT = 4'd6,
        S_STOP = 4'd7,
        S_DONE = 4'd8
    } state_e;

    state_e      state_q,       state_d;
    logic [23:0] value_q,       value_d;
    logic        dir_q,         dir_d;      // 1 = count up (already masked)
    logic [11:0] swc_inst_q,    swc_inst_d;
    logic        swc_inst_en_q, swc_inst_en_d;
    logic        cmd_ready_q,   cmd_ready_d;
    logic        busy_q,        busy_d;
    logic        done_q,        done_d;
    logic        aborted_q,     aborted_d;

    // Next-state and command capture
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        dir_d   = dir_q;

        case (state_q)
            S_INIT: begin
                if (bus.swc_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    value_d = bus.cmd_value;
                    dir_d   = bus.cmd_dir & DirUpEnable;
                    state_d = S_LD0;
                end
            end
            S_LD0: state_d = S_LD1;
            S_LD1: state_d = S_LD2;
            S_LD2: state_d = S_RUN;
            S_RUN: begin
                // A down count from zero has nothing to count: finish at once.
                if (!dir_q && (value_q == 24'd0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion wins over a simultaneous abort.
                if (bus.swc_ready) begin
                    state_d = S_DONE;
                end else if (bus.abort) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Output decode from the upcoming state; registered below
    always_comb begin
        swc_inst_d    = {OP_NOP, 8'h00};
        swc_inst_en_d = 1'b0;
        cmd_ready_d   = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_d)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            S_LD0: begin
                busy_d        = 1'b1;
                swc_inst_en_d = 1'b1;
                swc_inst_d    = {OP_LD0, value_d[7:0]};
            end
            S_LD1: begin
                busy_d        = 1'b1;
                swc_inst_en_d = 1'b1;
                swc_inst_d    = {OP_LD1, value_d[15:8]};
            end
            S_LD2: begin
                busy_d        = 1'b1;
                swc_inst_en_d = 1'b1;
                swc_inst_d    = {OP_LD2, value_d[23:16]};
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (dir_d || (value_d != 24'd0)) begin
                    swc_inst_en_d = 1'b1;
                    swc_inst_d    = {(dir_d ? OP_CCU : OP_CCD), 8'h00};
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
            end
            S_STOP: begin
                busy_d        = 1'b1;
                swc_inst_en_d = 1'b1;
                swc_inst_d    = {OP_CCS, 8'h00};
            end
            S_DONE: begin
                busy_d    = 1'b1;
                done_d    = 1'b1;
                // Only the path through Stop is an aborted completion.
                aborted_d = (state_q == S_STOP);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            value_q       <= 24'd0;
            dir_q         <= 1'b0;
            swc_inst_q    <= 12'h000;
            swc_inst_en_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            dir_q         <= dir_d;
            swc_inst_q    <= swc_inst_d;
            swc_inst_en_q <= swc_inst_en_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    assign bus.swc_inst    = swc_inst_q;
    assign bus.swc_inst_en = swc_inst_en_q;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_swc_driver.sv
// ---------------------------------------------------------------------------
// tb_swc_driver
// Self-checking bench for swc_driver. dut0 (DirUpEnable=1) is paired with a
// behavioural stopwatch model that executes the issued instructions and
// produces swc_ready; dut1 (DirUpEnable=0) sees swc_ready tied high by the
// bench. Expected instructions (with their cycle offset from acceptance) and
// expected done pulses are queued when a command is driven and popped as
// dut0 produces them.
// ---------------------------------------------------------------------------
module tb_swc_driver;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    swc_driver_if bus0();
    swc_driver_if bus1();

    swc_driver #(.DirUpEnable(1'b1)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    swc_driver #(.DirUpEnable(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Stopwatch model: ready means "counter next value is zero"
    logic [23:0] sw_cnt;
    logic        sw_run, sw_up;
    logic [23:0] sw_next;
    logic        sw_manual, sw_man_val;
    assign sw_next = sw_up ? (sw_cnt + 24'd1) : (sw_cnt - 24'd1);
    assign bus0.swc_ready = sw_manual ? sw_man_val : (sw_run ? (sw_next == 24'd0) : 1'b1);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_cnt <= 24'd0;
            sw_run <= 1'b0;
            sw_up  <= 1'b0;
        end else begin
            if (sw_run) begin
                sw_cnt <= sw_next;
                if (sw_next == 24'd0) sw_run <= 1'b0;
            end
            if (bus0.swc_inst_en) begin
                case (bus0.swc_inst[11:8])
                    4'h1: sw_cnt[7:0]   <= bus0.swc_inst[7:0];
                    4'h2: sw_cnt[15:8]  <= bus0.swc_inst[7:0];
                    4'h3: sw_cnt[23:16] <= bus0.swc_inst[7:0];
                    4'h6: begin sw_run <= 1'b1; sw_up <= 1'b1; end
                    4'h7: begin sw_run <= 1'b1; sw_up <= 1'b0; end
                    4'h8: sw_run <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int t_acc = 0;

    logic [11:0] exp_inst_q[$];
    int          exp_icyc_q[$];
    int          exp_done_q[$];
    bit          exp_abt_q[$];

    task automatic push_inst(input logic [11:0] inst, input int c);
        exp_inst_q.push_back(inst);
        exp_icyc_q.push_back(c);
    endtask

    task automatic push_done(input int c, input bit abt);
        exp_done_q.push_back(c);
        exp_abt_q.push_back(abt);
    endtask

    // Scoreboard consumer for dut0
    task automatic monitor();
        logic [11:0] e_i;
        int          e_c;
        bit          e_a;
        forever begin
            @(negedge clock);
            if (reset) begin
                n_cmp++;
                if (bus0.swc_inst_en) begin
                    if (exp_inst_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_inst: got %h at +%0d, want no instruction", bus0.swc_inst, cyc - t_acc);
                    end else begin
                        e_i = exp_inst_q.pop_front();
                        e_c = exp_icyc_q.pop_front();
                        if (bus0.swc_inst !== e_i || (cyc - t_acc) != e_c) begin
                            n_bad++;
                            $display("FAIL inst: got %h at +%0d, want %h at +%0d", bus0.swc_inst, cyc - t_acc, e_i, e_c);
                        end
                    end
                end else if (bus0.swc_inst !== 12'h000) begin
                    n_bad++;
                    $display("FAIL inst_idle_zero: got %h, want 000", bus0.swc_inst);
                end
                if (bus0.done) begin
                    n_cmp++;
                    if (exp_done_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_done: got done at +%0d, want none", cyc - t_acc);
                    end else begin
                        e_c = exp_done_q.pop_front();
                        e_a = exp_abt_q.pop_front();
                        if ((cyc - t_acc) != e_c || bus0.aborted !== e_a) begin
                            n_bad++;
                            $display("FAIL done: got +%0d aborted=%b, want +%0d aborted=%b", cyc - t_acc, bus0.aborted, e_c, e_a);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive_cmd(input logic [23:0] v, input logic d);
        int k = 0;
        while (bus0.cmd_ready !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        n_cmp++;
        if (bus0.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_ready_wait: got %b, want 1", bus0.cmd_ready);
        end
        bus0.cmd_valid = 1'b1;
        bus0.cmd_value = v;
        bus0.cmd_dir   = d;
        t_acc = cyc;
        @(negedge clock);
        bus0.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (bus0.done !== 1'b1 && k < budget) begin @(negedge clock); k++; end
        #1;
        n_cmp++;
        if (bus0.done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: got done=%b, want 1 within %0d cycles", name, bus0.done, budget);
        end
        n_cmp++;
        if (exp_inst_q.size() != 0 || exp_done_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover: got %0d inst/%0d done unconsumed, want 0/0", name, exp_inst_q.size(), exp_done_q.size());
        end
        exp_inst_q.delete(); exp_icyc_q.delete(); exp_done_q.delete(); exp_abt_q.delete();
    endtask

    task automatic wait_rel(input int rel);
        int k = 0;
        while (cyc < t_acc + rel && k < 100) begin @(negedge clock); k++; end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus0.cmd_ready, bus0.busy, bus0.done, bus0.aborted, bus0.swc_inst_en, bus0.swc_inst} !== 17'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b abt=%b en=%b inst=%h, want all 0",
                     bus0.cmd_ready, bus0.busy, bus0.done, bus0.aborted, bus0.swc_inst_en, bus0.swc_inst);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (bus0.cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL init_hold[%0d]: got cmd_ready=%b, want 0", i, bus0.cmd_ready);
            end
        end
        sw_man_val = 1'b1;
        #1;
        n_cmp++;
        if (bus0.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL init_ready_same: got cmd_ready=%b, want 0", bus0.cmd_ready);
        end
        @(negedge clock);
        n_cmp++;
        if (bus0.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL init_to_idle: got cmd_ready=%b, want 1", bus0.cmd_ready);
        end
        sw_manual = 1'b0;
    endtask

    task automatic test_down3();
        push_inst(12'h103, 1); push_inst(12'h200, 2); push_inst(12'h300, 3); push_inst(12'h700, 4);
        push_done(8, 1'b0);
        drive_cmd(24'h000003, 1'b0);
        n_cmp++;
        if (bus0.busy !== 1'b1 || bus0.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL down3_busy: got busy=%b rdy=%b, want 1/0", bus0.busy, bus0.cmd_ready);
        end
        wait_done("down3", 40);
        @(negedge clock);
        n_cmp++;
        if (bus0.busy !== 1'b0 || bus0.cmd_ready !== 1'b1 || bus0.done !== 1'b0) begin
            n_bad++;
            $display("FAIL down3_idle: got busy=%b rdy=%b done=%b, want 0/1/0", bus0.busy, bus0.cmd_ready, bus0.done);
        end
    endtask

    task automatic test_down0();
        push_inst(12'h100, 1); push_inst(12'h200, 2); push_inst(12'h300, 3);
        push_done(5, 1'b0);
        drive_cmd(24'h000000, 1'b0);
        wait_done("down0", 40);
    endtask

    task automatic test_up();
        push_inst(12'h1FE, 1); push_inst(12'h2FF, 2); push_inst(12'h3FF, 3); push_inst(12'h600, 4);
        push_done(7, 1'b0);
        drive_cmd(24'hFFFFFE, 1'b1);
        wait_done("up", 40);
    endtask

    task automatic test_abort();
        push_inst(12'h100, 1); push_inst(12'h201, 2); push_inst(12'h300, 3); push_inst(12'h700, 4);
        push_inst(12'h800, 11);
        push_done(12, 1'b1);
        drive_cmd(24'h000100, 1'b0);
        wait_rel(10);
        bus0.abort = 1'b1;
        @(negedge clock);
        bus0.abort = 1'b0;
        wait_done("abort", 40);
    endtask

    task automatic test_abort_race();
        push_inst(12'h102, 1); push_inst(12'h200, 2); push_inst(12'h300, 3); push_inst(12'h700, 4);
        push_done(7, 1'b0);
        drive_cmd(24'h000002, 1'b0);
        wait_rel(6);
        bus0.abort = 1'b1;
        @(negedge clock);
        bus0.abort = 1'b0;
        wait_done("abort_race", 40);
    endtask

    task automatic test_ignore();
        push_inst(12'h101, 1); push_inst(12'h200, 2); push_inst(12'h300, 3); push_inst(12'h700, 4);
        push_done(6, 1'b0);
        drive_cmd(24'h000001, 1'b0);
        bus0.abort     = 1'b1;
        bus0.cmd_valid = 1'b1;
        bus0.cmd_value = 24'hABCDEF;
        wait_rel(3);
        n_cmp++;
        if (bus0.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_ready: got cmd_ready=%b, want 0", bus0.cmd_ready);
        end
        wait_rel(5);
        bus0.abort     = 1'b0;
        bus0.cmd_valid = 1'b0;
        wait_done("ignore", 40);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (bus0.cmd_ready !== 1'b1 || bus0.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL ignore_no_queue[%0d]: got rdy=%b busy=%b, want 1/0", i, bus0.cmd_ready, bus0.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        push_inst(12'h100, 1); push_inst(12'h201, 2); push_inst(12'h300, 3); push_inst(12'h700, 4);
        drive_cmd(24'h000100, 1'b0);
        wait_rel(7);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus0.cmd_ready, bus0.busy, bus0.done, bus0.aborted, bus0.swc_inst_en, bus0.swc_inst} !== 17'h0) begin
            n_bad++;
            $display("FAIL midreset_clear: got rdy=%b busy=%b done=%b en=%b inst=%h, want all 0",
                     bus0.cmd_ready, bus0.busy, bus0.done, bus0.swc_inst_en, bus0.swc_inst);
        end
        n_cmp++;
        if (exp_inst_q.size() != 0) begin
            n_bad++;
            $display("FAIL midreset_pending: got %0d unissued inst, want 0", exp_inst_q.size());
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++;
            if (bus0.done !== 1'b0 || bus0.swc_inst_en !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_quiet[%0d]: got done=%b en=%b, want 0/0", i, bus0.done, bus0.swc_inst_en);
            end
        end
        n_cmp++;
        if (bus0.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_idle: got cmd_ready=%b, want 1", bus0.cmd_ready);
        end
    endtask

    task automatic test_dirup_off();
        logic [11:0] got_i[$];
        int          got_c[$];
        logic [11:0] ei[4];
        int          ec[4];
        int          dcyc;
        logic        dabt;
        int          t1;
        int          k;
        ei = '{12'h1FE, 12'h2FF, 12'h3FF, 12'h700};
        ec = '{1, 2, 3, 4};
        dcyc = -1;
        dabt = 1'bx;
        k = 0;
        while (bus1.cmd_ready !== 1'b1 && k < 50) begin @(negedge clock); k++; end
        bus1.cmd_valid = 1'b1;
        bus1.cmd_value = 24'hFFFFFE;
        bus1.cmd_dir   = 1'b1;
        t1 = cyc;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            bus1.cmd_valid = 1'b0;
            if (bus1.swc_inst_en) begin
                got_i.push_back(bus1.swc_inst);
                got_c.push_back(cyc - t1);
            end
            if (bus1.done && dcyc < 0) begin
                dcyc = cyc - t1;
                dabt = bus1.aborted;
            end
        end
        n_cmp++;
        if (got_i.size() != 4) begin
            n_bad++;
            $display("FAIL dirup_off_count: got %0d instructions, want 4", got_i.size());
        end
        for (int i = 0; i < 4 && i < got_i.size(); i++) begin
            n_cmp++;
            if (got_i[i] !== ei[i] || got_c[i] != ec[i]) begin
                n_bad++;
                $display("FAIL dirup_off_inst[%0d]: got %h at +%0d, want %h at +%0d", i, got_i[i], got_c[i], ei[i], ec[i]);
            end
        end
        n_cmp++;
        if (dcyc != 6 || dabt !== 1'b0) begin
            n_bad++;
            $display("FAIL dirup_off_done: got +%0d aborted=%b, want +6 aborted=0", dcyc, dabt);
        end
    endtask

    initial begin
        bus0.cmd_valid = 1'b0;
        bus0.cmd_value = 24'd0;
        bus0.cmd_dir   = 1'b0;
        bus0.abort     = 1'b0;
        bus1.cmd_valid = 1'b0;
        bus1.cmd_value = 24'd0;
        bus1.cmd_dir   = 1'b0;
        bus1.abort     = 1'b0;
        bus1.swc_ready = 1'b1;
        sw_manual      = 1'b1;
        sw_man_val     = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_down3();
        test_down0();
        test_up();
        test_abort();
        test_abort_race();
        test_ignore();
        test_reset_mid();
        test_dirup_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/swc_driver.md
SWC_DRIVER -- requirements
Module: swc_driver

Interface
REQ-001 Parameter: DirUpEnable, default 1, when 0 cmd_dir is ignored and every command counts down.
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  driver accepts a command this cycle.
REQ-006 cmd_value  input  24  start value loaded into the stopwatch counter.
REQ-007 cmd_dir  input  1  0 = count down to zero (CCD), 1 = count up to wrap (CCU).
REQ-008 abort  input  1  request early stop of a running count.
REQ-009 swc_inst  output  12  instruction to stopwatch: [11:8] opcode, [7:0] immediate.
REQ-010 swc_inst_en  output  1  swc_inst valid this cycle.
REQ-011 swc_ready  input  1  stopwatch ready (counter next value == 0).
REQ-012 busy  output  1  command in progress.
REQ-013 done  output  1  one-cycle pulse at command completion.
REQ-014 aborted  output  1  valid with done; 1 = completion caused by abort.

Function
REQ-015 Opcodes: NOP 4'h0, LD0 4'h1, LD1 4'h2, LD2 4'h3, CCU 4'h6, CCD 4'h7, CCS 4'h8; no other opcode is ever driven.
REQ-016 States: Init, Idle, Ld0, Ld1, Ld2, Run, Wait, Stop, Done; the encoding is implementation choice and all unused encodings go to Init.
REQ-017 Init: swc_inst_en=0; the driver moves to Idle on the first cycle that swc_ready=1.
REQ-018 Idle: cmd_ready=1, busy=0; cmd_valid=1 captures cmd_value and the effective direction (cmd_dir & DirUpEnable), then the driver moves to Ld0.
REQ-019 cmd_ready is 0 in every state except Idle; cmd_valid outside Idle is ignored and no command is queued.
REQ-020 Ld0, Ld1, Ld2 each last exactly one cycle, with swc_inst_en=1 and swc_inst = {LD0,v[7:0]}, then {LD1,v[15:8]}, then {LD2,v[23:16]}, issued on consecutive cycles.
REQ-021 Run lasts one cycle and branches as follows:
- Down with v==0: no instruction (swc_inst_en=0); go to Done, aborted=0.
- Down with v!=0: issue {CCD,8'h00}; go to Wait.
- Up: issue {CCU,8'h00}; go to Wait. An up count with v==0 runs 2^24 cycles to wrap.
REQ-022 Wait: swc_inst_en=0; if swc_ready=1, go to Done with aborted=0; else if abort=1, go to Stop; else stay.
REQ-023 In Wait, swc_ready=1 and abort=1 in the same cycle resolve as normal completion: no CCS is issued and aborted=0.
REQ-024 Stop lasts one cycle with swc_inst_en=1 and swc_inst={CCS,8'h00}, then goes to Done with aborted=1.
REQ-025 abort is ignored in every state except Wait.
REQ-026 Done lasts one cycle with done=1, aborted valid and swc_inst_en=0, then goes to Idle.
REQ-027 busy=1 in Ld0, Ld1, Ld2, Run, Wait, Stop and Done.
REQ-028 Command latency: accept at cycle T; LD0 at T+1; CCD/CCU at T+4; for down with v=N, done at T+N+5.
REQ-029 Whenever swc_inst_en=0, swc_inst = 12'h000.
REQ-030 All outputs are registered; no combinational path exists from any input to any output.

Reset
REQ-031 reset=0 asynchronously forces state=Init, swc_inst=0, swc_inst_en=0, cmd_ready=0, busy=0, done=0, aborted=0, and clears the captured value and direction.
REQ-032 Reset asserted mid-command (any state) abandons the command with no done pulse; after release, the driver re-enters Idle only via Init and swc_ready=1.

Verification
REQ-033 Reset release with swc_ready held 0 for 3 cycles, then 1 -> cmd_ready stays 0 until the cycle after swc_ready=1, then 1.
REQ-034 Command v=24'h000003, dir=0 -> swc_inst sequence 12'h103, 12'h200, 12'h300, 12'h700; done at T+8 with aborted=0.
REQ-035 Command v=0, dir=0 -> LD0/LD1/LD2 with imm 0, no CCD issued, done at T+5.
REQ-036 Command v=24'hFFFFFE, dir=1 -> sequence 12'h1FE, 12'h2FF, 12'h3FF, 12'h600; done when swc_ready rises, aborted=0; with DirUpEnable=0, the same stimulus issues 12'h700 instead.
REQ-037 Command v=24'h000100, dir=0 with abort pulsed at T+10 -> 12'h800 at T+11, done=1 and aborted=1 at T+12; abort and swc_ready both 1 in Wait -> no CCS, aborted=0.
REQ-038 reset=0 asserted during Wait -> outputs clear the same cycle, no done pulse, swc_inst_en=0 thereafter until a new command is accepted.
